// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and the angle fold helper for the CORDIC
// angle sequencer and its sideband delay line.
package cordic_pkg;

   localparam int PHASE_W    = 32;
   localparam int XY_W       = 16;
   localparam int CORDIC_LAT = 16;
   localparam int CNT_W      = 16;
   localparam int DRAIN_W    = $clog2(CORDIC_LAT + 1);

   localparam logic [XY_W-1:0]    AMP    = 16'd19429;
   localparam logic [PHASE_W-1:0] DEG90  = 32'h4000_0000;
   localparam logic [PHASE_W-1:0] DEG180 = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [PHASE_W-1:0] angle;
      logic               neg;
   } fold_t;

   // Phases in [90, 270) deg land in the upper half once shifted by 90 deg;
   // those are rotated by 180 deg and flagged so the consumer negates the result.
   function automatic fold_t fold_phase(input logic [PHASE_W-1:0] p);
      fold_t              r;
      logic [PHASE_W-1:0] shifted;
      shifted = p + DEG90;
      r.neg   = shifted[PHASE_W-1];
      r.angle = r.neg ? (p - DEG180) : p;
      return r;
   endfunction

endpackage

// File: rtl/cordic_flag_delay.sv
// Fixed-depth shift register for a {valid, neg} sideband pair, used to line
// flags up with the output of a fixed-latency pipeline.
module cordic_flag_delay #(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_i,
   input  logic neg_i,
   output logic valid_o,
   output logic neg_o
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] neg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         neg_q   <= '0;
      end else begin
         valid_q <= (valid_q << 1) | DEPTH'(valid_i);
         neg_q   <= (neg_q << 1) | DEPTH'(neg_i);
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign neg_o   = neg_q[DEPTH-1];

endmodule

// File: rtl/cordic_angle_seq.sv
// Phase-accumulator burst sequencer feeding a CORDIC rotator with folded
// angles, constant Xin/Yin, and latency-aligned valid/negate flags.
module cordic_angle_seq
   import cordic_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   burst_len,
   input  logic [PHASE_W-1:0] phase_init,
   input  logic [PHASE_W-1:0] tuning_word,
   output logic [PHASE_W-1:0] angle,
   output logic [XY_W-1:0]    Xin,
   output logic [XY_W-1:0]    Yin,
   output logic               angle_valid,
   output logic               res_valid,
   output logic               res_neg,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sample_cnt
);

   state_t             state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASE_W-1:0] tw_q, tw_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic [PHASE_W-1:0] angle_q, angle_d;
   logic               angle_valid_q, angle_valid_d;
   logic               fold_q, fold_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
   fold_t              fold_res;

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      tw_d          = tw_q;
      remaining_d   = remaining_q;
      drain_d       = drain_q;
      angle_d       = angle_q;
      fold_d        = fold_q;
      angle_valid_d = 1'b0;
      done_d        = 1'b0;
      fold_res      = fold_phase(phase_q);

      case (state_q)
         IDLE: begin
            if (start && (burst_len != '0)) begin
               fold_res      = fold_phase(phase_init);
               tw_d          = tuning_word;
               angle_d       = fold_res.angle;
               fold_d        = fold_res.neg;
               angle_valid_d = 1'b1;
               phase_d       = phase_init + tuning_word;
               remaining_d   = burst_len - CNT_W'(1);
               if (burst_len > CNT_W'(1)) begin
                  state_d = RUN;
               end else begin
                  state_d = DRAIN;
                  drain_d = DRAIN_W'(CORDIC_LAT);
               end
            end
         end
         RUN: begin
            angle_d       = fold_res.angle;
            fold_d        = fold_res.neg;
            angle_valid_d = 1'b1;
            phase_d       = phase_q + tw_q;
            remaining_d   = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
               state_d = DRAIN;
               drain_d = DRAIN_W'(CORDIC_LAT);
            end
         end
         DRAIN: begin
            // The last angle is still visible while this counter is first loaded,
            // so the idle/done edge lands CORDIC_LAT+1 cycles after it.
            if (drain_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q - DRAIN_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d       = (state_d != IDLE);
      sample_cnt_d = sample_cnt_q + CNT_W'(angle_valid_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         phase_q       <= '0;
         tw_q          <= '0;
         remaining_q   <= '0;
         drain_q       <= '0;
         angle_q       <= '0;
         fold_q        <= 1'b0;
         angle_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         sample_cnt_q  <= '0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         tw_q          <= tw_d;
         remaining_q   <= remaining_d;
         drain_q       <= drain_d;
         angle_q       <= angle_d;
         fold_q        <= fold_d;
         angle_valid_q <= angle_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         sample_cnt_q  <= sample_cnt_d;
      end
   end

   cordic_flag_delay #(
      .DEPTH (CORDIC_LAT)
   ) u_flag_delay (
      .clk     (clk),
      .rst     (rst),
      .valid_i (angle_valid_q),
      .neg_i   (fold_q),
      .valid_o (res_valid),
      .neg_o   (res_neg)
   );

   assign angle       = angle_q;
   assign Xin         = AMP;
   assign Yin         = '0;
   assign angle_valid = angle_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_cordic_angle_seq.sv
// Self-checking bench for cordic_angle_seq: directed burst table, random
// bursts against a reference model, and hand-written corner sequences.
module tb_cordic_angle_seq;

   localparam int LAT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] burst_len;
   logic [31:0] phase_init;
   logic [31:0] tuning_word;
   logic [31:0] angle;
   logic [15:0] Xin;
   logic [15:0] Yin;
   logic        angle_valid;
   logic        res_valid;
   logic        res_neg;
   logic        busy;
   logic        done;
   logic [15:0] sample_cnt;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] exp_cnt     = 16'd0;

   always #5 clk = ~clk;

   cordic_angle_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .burst_len   (burst_len),
      .phase_init  (phase_init),
      .tuning_word (tuning_word),
      .angle       (angle),
      .Xin         (Xin),
      .Yin         (Yin),
      .angle_valid (angle_valid),
      .res_valid   (res_valid),
      .res_neg     (res_neg),
      .busy        (busy),
      .done        (done),
      .sample_cnt  (sample_cnt)
   );

   typedef struct {
      int          len;
      logic [31:0] p0;
      logic [31:0] tw;
      logic [31:0] first_ang;
      logic [31:0] last_ang;
      logic        last_neg;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the legal CORDIC range is signed [-90, +90) deg; anything
   // outside it is moved by half a turn and marked for negation.
   task automatic model_fold(input logic [31:0] p, output logic [31:0] a, output logic f);
      int signed s;
      s = $signed(p);
      if (s >= (1 <<< 30) || s < -(1 <<< 30)) begin
         f = 1'b1;
         a = p + 32'h8000_0000;
      end else begin
         f = 1'b0;
         a = p;
      end
   endtask

   task automatic model_sample(input logic [31:0] p0, input logic [31:0] tw, input int k,
                               output logic [31:0] a, output logic f);
      logic [31:0] p;
      p = p0 + 32'(k) * tw;
      model_fold(p, a, f);
   endtask

   // Called at a negedge; runs one burst and returns at the negedge of the done cycle.
   task automatic run_burst(input int len, input logic [31:0] p0, input logic [31:0] tw,
                            input bit intrude, output logic [31:0] first_ang,
                            output logic [31:0] last_ang, output logic last_neg);
      logic [31:0] ea, last_a;
      logic        ef, dummy_f;
      int          emitted;
      start       = 1'b1;
      burst_len   = 16'(len);
      phase_init  = p0;
      tuning_word = tw;
      first_ang   = 'x;
      last_ang    = 'x;
      last_neg    = 1'bx;
      model_sample(p0, tw, len - 1, last_a, dummy_f);
      @(posedge clk);
      for (int c = 1; c <= len + LAT + 1; c++) begin
         @(negedge clk);
         if (intrude && c == 2) begin
            start     = 1'b1;
            burst_len = 16'd9;
         end else begin
            start = 1'b0;
         end
         tuning_word = $urandom;
         phase_init  = $urandom;
         chk("angle_valid", 32'(angle_valid), 32'(c <= len));
         if (c <= len) begin
            model_sample(p0, tw, c - 1, ea, ef);
            chk("angle", angle, ea);
         end else begin
            chk("angle_hold", angle, last_a);
         end
         if (c == 1) first_ang = angle;
         if (c == len) last_ang = angle;
         chk("res_valid", 32'(res_valid), 32'(c > LAT && c - LAT <= len));
         if (c > LAT && c - LAT <= len) begin
            model_sample(p0, tw, c - LAT - 1, ea, ef);
            chk("res_neg", 32'(res_neg), 32'(ef));
            if (c - LAT == len) last_neg = res_neg;
         end
         chk("busy", 32'(busy), 32'(c <= len + LAT));
         chk("done", 32'(done), 32'(c == len + LAT + 1));
         emitted = (c < len) ? c : len;
         chk("sample_cnt", 32'(sample_cnt), 32'(exp_cnt + 16'(emitted)));
      end
      exp_cnt = exp_cnt + 16'(len);
      $display("burst len=%0d p0=%h tw=%h first=%h last=%h cnt=%0d", len, p0, tw,
               first_ang, last_ang, sample_cnt);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_angle"}, angle, 32'h0);
      chk({tag, "_xin"}, 32'(Xin), 32'd19429);
      chk({tag, "_yin"}, 32'(Yin), 32'd0);
      chk({tag, "_angle_valid"}, 32'(angle_valid), 32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_neg"}, 32'(res_neg), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
   endtask

   initial begin
      logic [31:0] fa, la;
      logic        ln;

      tbl[0] = '{4, 32'h0000_0000, 32'h2000_0000, 32'h0000_0000, 32'hE000_0000, 1'b1};
      tbl[1] = '{1, 32'h6AAA_AAAA, 32'h1234_5678, 32'hEAAA_AAAA, 32'hEAAA_AAAA, 1'b1};
      tbl[2] = '{2, 32'hF000_0000, 32'h2000_0000, 32'hF000_0000, 32'h1000_0000, 1'b0};
      tbl[3] = '{3, 32'h4000_0000, 32'h0000_0000, 32'hC000_0000, 32'hC000_0000, 1'b1};

      rst         = 1'b1;
      start       = 1'b0;
      burst_len   = '0;
      phase_init  = '0;
      tuning_word = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_state("reset");
      $display("reset release checked");

      // Directed table; bursts run back to back so each start lands in the
      // previous burst's done cycle. Entry 0 also gets a second start mid-RUN.
      for (int i = 0; i < 4; i++) begin
         run_burst(tbl[i].len, tbl[i].p0, tbl[i].tw, (i == 0), fa, la, ln);
         chk("tbl_first_angle", fa, tbl[i].first_ang);
         chk("tbl_last_angle", la, tbl[i].last_ang);
         chk("tbl_last_res_neg", 32'(ln), 32'(tbl[i].last_neg));
      end

      // burst_len = 0 must be ignored entirely.
      @(negedge clk);
      start     = 1'b1;
      burst_len = 16'd0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("len0_angle_valid", 32'(angle_valid), 32'd0);
         chk("len0_busy", 32'(busy), 32'd0);
         chk("len0_sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
         @(negedge clk);
      end
      $display("zero-length start checked");

      for (int r = 0; r < 20; r++) begin
         run_burst(int'($urandom_range(1, 7)), $urandom, $urandom, ($urandom_range(0, 3) == 0),
                   fa, la, ln);
      end

      // Reset while the third sample is on the output.
      @(negedge clk);
      start       = 1'b1;
      burst_len   = 16'd6;
      phase_init  = $urandom;
      tuning_word = $urandom;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_angle_valid", 32'(angle_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 16'd0;
      chk_reset_state("midrst");
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("post_rst_res_valid", 32'(res_valid), 32'd0);
         chk("post_rst_angle_valid", 32'(angle_valid), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end
      $display("mid-burst reset checked");

      run_burst(3, 32'h3000_0000, 32'h0800_0000, 1'b0, fa, la, ln);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
